// File: rtl/bidir_bus_agent.sv
// Far-end agent on a shared half-duplex tri-state bus.
//
// While the peer drives the bus (peer_oe=1) the agent listens and streams each sampled word
// out on rx_data/rx_valid. Once the peer releases the bus, the agent waits TURN_CYC idle
// cycles. It then takes ownership and drives words accepted from a valid/ready source. It
// keeps ownership until the peer drives again or reset. A peer drive during ownership is
// contention: the agent releases the bus and raises a sticky collision flag.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   peer_oe         peer output enable (1 = peer drives bidir)
//   bidir           shared bus; driven with the held word while drive_en=1, else z
//   drive_en        agent is driving bidir (decoded straight from the state register)
//   tx_data/valid   word source; tx_ready accepts it (combinational)
//   rx_data/valid   last word sampled from the peer; one-cycle strobe on update
//   tx_count        words accepted since reset, modulo 2^16
//   collision       sticky contention flag; clr_collision clears it
module bidir_bus_agent #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             peer_oe,
    inout  wire  [WIDTH-1:0] bidir,
    output logic             drive_en,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic [15:0]      tx_count,
    output logic             collision,
    input  logic             clr_collision
);

    typedef enum logic [1:0] {StListen, StTurn, StOwn} state_e;

    // Turn counter counts down to zero, so it is loaded with one less than the gap length.
    localparam logic [3:0] TurnLoad = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);

    state_e           state_q, state_d;
    logic [3:0]       turn_cnt_q, turn_cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic [15:0]      tx_count_q, tx_count_d;
    logic             collision_q, collision_d;

    // Decoded from the state flop only, so an asynchronous reset releases the bus at once.
    assign drive_en  = (state_q == StOwn);
    assign tx_ready  = drive_en && !peer_oe;
    assign bidir     = drive_en ? dout_q : {WIDTH{1'bz}};
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_count  = tx_count_q;
    assign collision = collision_q;

    always_comb begin
        state_d     = state_q;
        turn_cnt_d  = turn_cnt_q;
        dout_d      = dout_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_count_d  = tx_count_q;
        collision_d = collision_q;

        unique case (state_q)
            StListen: begin
                if (peer_oe) begin
                    rx_data_d  = bidir;
                    rx_valid_d = 1'b1;
                end else if (TURN_CYC == 0) begin
                    state_d = StOwn;
                end else begin
                    state_d    = StTurn;
                    turn_cnt_d = TurnLoad;
                end
            end
            StTurn: begin
                if (peer_oe) begin
                    // Peer came back before we took the bus: abort and keep listening.
                    state_d    = StListen;
                    rx_data_d  = bidir;
                    rx_valid_d = 1'b1;
                end else if (turn_cnt_q == 4'd0) begin
                    state_d = StOwn;
                end else begin
                    turn_cnt_d = turn_cnt_q - 4'd1;
                end
            end
            StOwn: begin
                if (peer_oe) begin
                    // Contention: release, no accept and no sample on this edge.
                    state_d = StListen;
                end else if (tx_valid) begin
                    dout_d     = tx_data;
                    tx_count_d = tx_count_q + 16'd1;
                end
            end
            default: state_d = StListen;
        endcase

        // Setting wins over a simultaneous clear.
        if (drive_en && peer_oe) begin
            collision_d = 1'b1;
        end else if (clr_collision) begin
            collision_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StListen;
            turn_cnt_q  <= 4'd0;
            dout_q      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_count_q  <= 16'd0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            turn_cnt_q  <= turn_cnt_d;
            dout_q      <= dout_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_count_q  <= tx_count_d;
            collision_q <= collision_d;
        end
    end

endmodule
